// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI3 slave backed by a word-addressed on-chip RAM.
// It serves one transaction at a time. Bursts are INCR or FIXED and carry up to 16 beats.
// WRAP bursts are handled as INCR.
// Optional feature macro: AXI_RAM_DECERR_EN. When it is defined, an access above the RAM
// range returns DECERR. Such a read returns zero data and such a write leaves the RAM
// unchanged. When it is undefined, addresses alias modulo MEM_WORDS*4.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ar* / arvalid / arready          read address channel (arlen[3:0] used)
//   r*  / rvalid  / rready           read data channel
//   aw* / awvalid / awready          write address channel
//   w*  / wvalid  / wready           write data channel (wid, wlast ignored)
//   b*  / bvalid  / bready           write response channel
//   *lock / *cache / *prot           accepted and ignored
module axi_ram_slave #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

`ifdef AXI_RAM_DECERR_EN
  localparam bit DecerrEn = 1'b1;
`else
  localparam bit DecerrEn = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_BRESP} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        werr_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic        rvalid_q;
  logic        wready_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
  logic        bvalid_q;

  logic [31:0] mem_q [MEM_WORDS];

  // Address of the following beat (FIXED bursts keep the same address)
  logic [31:0] next_addr;
  assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);

  // Range checks; always in range when DECERR reporting is disabled
  logic ar_ok, nxt_ok, cur_ok;
  assign ar_ok  = !DecerrEn || (araddr[31:IDX_W+2] == '0);
  assign nxt_ok = !DecerrEn || (next_addr[31:IDX_W+2] == '0);
  assign cur_ok = !DecerrEn || (addr_q[31:IDX_W+2] == '0);

  logic [IDX_W-1:0] ar_idx, nxt_idx, cur_idx;
  assign ar_idx  = araddr[IDX_W+1:2];
  assign nxt_idx = next_addr[IDX_W+1:2];
  assign cur_idx = addr_q[IDX_W+1:2];

  logic [31:0] ar_word, nxt_word;
  assign ar_word  = ar_ok  ? mem_q[ar_idx]  : 32'd0;
  assign nxt_word = nxt_ok ? mem_q[nxt_idx] : 32'd0;

  logic [3:0] cnt_inc;
  assign cnt_inc = 4'(cnt_q + 4'd1);

  // Address acceptance is combinational; a pending write takes priority over a read
  assign awready = (state_q == S_IDLE) && awvalid;
  assign arready = (state_q == S_IDLE) && arvalid && !awvalid;

  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;
  assign wready = wready_q;
  assign bid    = bid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

  // RAM write port: byte lanes enabled by wstrb, contents survive reset
  always @(posedge clk) begin
    if (!rst && state_q == S_WR && wvalid && cur_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[cur_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      werr_q   <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awvalid) begin
            addr_q   <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            cnt_q    <= '0;
            bid_q    <= awid;
            werr_q   <= 1'b0;
            wready_q <= 1'b1;
            state_q  <= S_WR;
          end else if (arvalid) begin
            // First beat is fetched during the handshake so rvalid rises next cycle
            addr_q   <= araddr;
            len_q    <= arlen[3:0];
            size_q   <= arsize;
            burst_q  <= arburst;
            cnt_q    <= '0;
            rid_q    <= arid;
            rdata_q  <= ar_word;
            rresp_q  <= ar_ok ? RESP_OKAY : RESP_DECERR;
            rlast_q  <= (arlen[3:0] == 4'd0);
            rvalid_q <= 1'b1;
            state_q  <= S_RD;
          end
        end
        S_RD: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              addr_q  <= next_addr;
              cnt_q   <= cnt_inc;
              rdata_q <= nxt_word;
              rresp_q <= nxt_ok ? RESP_OKAY : RESP_DECERR;
              rlast_q <= (cnt_inc == len_q);
            end
          end
        end
        S_WR: begin
          // Burst end comes from the beat count; wlast is not consulted
          if (wvalid) begin
            if (cnt_q == len_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || !cur_ok) ? RESP_DECERR : RESP_OKAY;
              state_q  <= S_BRESP;
            end else begin
              werr_q <= werr_q || !cur_ok;
              addr_q <= next_addr;
              cnt_q  <= cnt_inc;
            end
          end
        end
        S_BRESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{arlen[7:4], arlock, arcache, arprot,
                       awlock, awcache, awprot, wid, wlast};

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed table-driven bench for axi_ram_slave
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

`ifdef AXI_RAM_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  axi_ram_slave #(.MEM_WORDS(1024), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
    .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Read results
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id;
  int          rd_cycles, rd_lat, rd_arwait, rd_n;
  // Write results
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;
  int          wr_lat;

  // Starts just after a rising edge; ends just after a rising edge with the DUT idle
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    bit rr;
    bit stalled;
    logic [31:0] hold_d;
    logic hold_l;
    araddr = addr; arlen = {4'h0, len}; arid = id; arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    rd_arwait = 0;
    while (!arready && rd_arwait < 20) begin @(posedge clk); #2; rd_arwait++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rd_lat = 0;
    while (!rvalid && rd_lat < 20) begin @(posedge clk); #1; rd_lat++; end
    rd_id = rid;
    rd_n = 0; rd_cycles = 0; rr = 1'b1; stalled = 1'b0;
    while (rd_n <= int'(len) && rd_cycles < 64) begin
      rready = rr;
      #1;
      if (rvalid && rr) begin
        rd_data[rd_n] = rdata; rd_last[rd_n] = rlast; rd_resp[rd_n] = rresp;
        rd_n++;
      end else if (rvalid) begin
        hold_d = rdata; hold_l = rlast; stalled = 1'b1;
      end
      @(posedge clk); #1;
      rd_cycles++;
      if (stalled) begin
        check("stall_rdata", rdata, hold_d);
        check("stall_rlast", 32'(rlast), 32'(hold_l));
        check("stall_rvalid", 32'(rvalid), 32'd1);
        stalled = 1'b0;
      end
      if (toggle) rr = !rr;
    end
    rready = 1'b0;
    check("r_count", rd_n, int'(len) + 1);
    #1;
    check("r_idle", 32'(rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] data0,
                          input logic [3:0] strb, input logic [3:0] id, input logic [2:0] size);
    int k;
    awaddr = addr; awlen = len; awid = id; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    #1;
    k = 0;
    while (!awready && k < 20) begin @(posedge clk); #2; k++; end
    check("aw_accept", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = data0 + 32'(i); wstrb = strb; wlast = 1'b0;
      #1;
      k = 0;
      while (!wready && k < 20) begin @(posedge clk); #2; k++; end
      if (i == 0) check("w_ready_lat", k, 0);
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
    #1;
    wr_lat = 0;
    while (!bvalid && wr_lat < 20) begin @(posedge clk); #2; wr_lat++; end
    wr_resp = bresp; wr_id = bid;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    #1;
    check("b_idle", 32'(bvalid), 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [31:0] exp;   // read data for reads; unused for writes (expect OKAY)
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'h1, 3'd2, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 4'h3, 3'd2, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10, 32'h11223344, 4'hF, 4'h2, 3'd2, 32'h0};
    vecs[3]  = '{1'b1, 32'h13, 32'hAA000000, 4'h8, 4'h4, 3'd0, 32'h0};
    vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 4'h6, 3'd2, 32'hAA223344};
    vecs[5]  = '{1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 4'h7, 3'd2, 32'h0};
    vecs[6]  = '{1'b1, 32'h14, 32'h0000BEEF, 4'h3, 4'h8, 3'd1, 32'h0};
    vecs[7]  = '{1'b0, 32'h14, 32'h0,        4'h0, 4'h9, 3'd2, 32'hA5A5BEEF};
    vecs[8]  = '{1'b1, 32'h20, 32'h10000020, 4'hF, 4'hA, 3'd2, 32'h0};
    vecs[9]  = '{1'b1, 32'h24, 32'h10000024, 4'hF, 4'hB, 3'd2, 32'h0};
    vecs[10] = '{1'b1, 32'h28, 32'h10000028, 4'hF, 4'hC, 3'd2, 32'h0};
    vecs[11] = '{1'b1, 32'h2C, 32'h1000002C, 4'hF, 4'hD, 3'd2, 32'h0};
    vecs[12] = '{1'b0, 32'h2C, 32'h0,        4'h0, 4'hF, 3'd2, 32'h1000002C};

    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_resp", 32'({rresp, bresp}), 32'd0);

    // Single-beat table
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr) begin
        do_write(vecs[v].addr, 4'd0, vecs[v].data, vecs[v].strb, vecs[v].id, vecs[v].size);
        check($sformatf("v%0d_bresp", v), 32'(wr_resp), 32'd0);
        check($sformatf("v%0d_bid", v), 32'(wr_id), 32'(vecs[v].id));
        check($sformatf("v%0d_blat", v), wr_lat, 0);
      end else begin
        do_read(vecs[v].addr, 4'd0, vecs[v].id, vecs[v].size, 2'b01, 1'b0);
        check($sformatf("v%0d_rdata", v), rd_data[0], vecs[v].exp);
        check($sformatf("v%0d_rresp", v), 32'(rd_resp[0]), 32'd0);
        check($sformatf("v%0d_rlast", v), 32'(rd_last[0]), 32'd1);
        check($sformatf("v%0d_rid", v), 32'(rd_id), 32'(vecs[v].id));
        check($sformatf("v%0d_rlat", v), rd_lat, 0);
      end
    end

    // INCR 4-beat read, rready held high: back-to-back beats
    do_read(32'h20, 4'd3, 4'h5, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_d%0d", i), rd_data[i], 32'h10000020 + 32'(4 * i));
      check($sformatf("incr_l%0d", i), 32'(rd_last[i]), 32'(i == 3));
    end
    check("incr_cycles", rd_cycles, 4);
    check("incr_lat", rd_lat, 0);

    // Same read with rready toggling 1,0
    do_read(32'h20, 4'd3, 4'h6, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++)
      check($sformatf("tog_d%0d", i), rd_data[i], 32'h10000020 + 32'(4 * i));
    check("tog_last", 32'(rd_last[3]), 32'd1);

    // FIXED burst repeats one word
    do_read(32'h24, 4'd2, 4'h7, 3'd2, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++)
      check($sformatf("fixed_d%0d", i), rd_data[i], 32'h10000024);

    // Halfword INCR: address steps by 2
    do_read(32'h20, 4'd3, 4'h8, 3'd1, 2'b01, 1'b0);
    check("half_d0", rd_data[0], 32'h10000020);
    check("half_d1", rd_data[1], 32'h10000020);
    check("half_d2", rd_data[2], 32'h10000024);
    check("half_d3", rd_data[3], 32'h10000024);

    // 2-beat write with wlast never asserted; B follows the beat count
    do_write(32'h30, 4'd1, 32'h00000300, 4'hF, 4'h9, 3'd2);
    check("wb2_blat", wr_lat, 0);
    check("wb2_bid", 32'(wr_id), 32'h9);
    do_read(32'h30, 4'd1, 4'h1, 3'd2, 2'b01, 1'b0);
    check("wb2_d0", rd_data[0], 32'h00000300);
    check("wb2_d1", rd_data[1], 32'h00000301);

    // Simultaneous AR and AW: write wins, read follows with the new data
    awaddr = 32'h40; awlen = 4'd0; awid = 4'h2; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    araddr = 32'h40; arlen = 8'd0; arid = 4'hC; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    check("both_awready", 32'(awready), 32'd1);
    check("both_arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h4444CCCC; wstrb = 4'hF;
    #1;
    check("both_wr_arready", 32'(arready), 32'd0);
    check("both_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    #1;
    check("both_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    #1;
    check("both_ar_after_b", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    #1;
    check("both_rvalid", 32'(rvalid), 32'd1);
    check("both_rdata", rdata, 32'h4444CCCC);
    check("both_rid", 32'(rid), 32'hC);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Reset during beat 1 of a 4-beat read
    araddr = 32'h20; arlen = 8'd3; arid = 4'h4; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    check("rstb_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    check("rstb_beat1", rdata, 32'h10000024);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rready = 1'b0;
    #1;
    check("rstb_rvalid", 32'(rvalid), 32'd0);
    check("rstb_rlast", 32'(rlast), 32'd0);
    check("rstb_bvalid", 32'(bvalid), 32'd0);
    check("rstb_rdata", rdata, 32'd0);
    do_read(32'h28, 4'd0, 4'h3, 3'd2, 2'b01, 1'b0);
    check("rstb_ar_wait", rd_arwait, 0);
    check("rstb_newdata", rd_data[0], 32'h10000028);

    // Out-of-range address 0x1000
    do_write(32'h0, 4'd0, 32'h55AA55AA, 4'hF, 4'h1, 3'd2);
    do_write(32'h1000, 4'd0, 32'h12345678, 4'hF, 4'h2, 3'd2);
    check("oor_bresp", 32'(wr_resp), DEC ? 32'd3 : 32'd0);
    do_read(32'h0, 4'd0, 4'h1, 3'd2, 2'b01, 1'b0);
    check("oor_word0", rd_data[0], DEC ? 32'h55AA55AA : 32'h12345678);
    do_read(32'h1000, 4'd0, 4'h1, 3'd2, 2'b01, 1'b0);
    check("oor_rdata", rd_data[0], DEC ? 32'h0 : 32'h12345678);
    check("oor_rresp", 32'(rd_resp[0]), DEC ? 32'd3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
